// File: rtl/seq_mult_param.sv
// Parametrised sequential shift-add multiplier with start/busy/done handshake.
// Signed mode multiplies magnitudes and negates the product when the operand signs differ.
module seq_mult_param #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          SIGNED_EN = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [2:0] {StIdle, StLoad, StAdd, StShift, StDone} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   md_q, md_d;
  logic [WIDTH-1:0]   mr_q, mr_d;
  logic               sgn_q, sgn_d;
  logic               neg_q, neg_d;
  logic [2*WIDTH:0]   acc_q, acc_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [2*WIDTH-1:0] product_q, product_d;

  logic [WIDTH-1:0]   md_mag, mr_mag;
  logic [2*WIDTH:0]   acc_shr;
  logic [CntW-1:0]    cnt_inc;

  // In LOAD, md_q/mr_q still hold the raw captured operands.
  assign md_mag  = (sgn_q && md_q[WIDTH-1]) ? -md_q : md_q;
  assign mr_mag  = (sgn_q && mr_q[WIDTH-1]) ? -mr_q : mr_q;
  assign acc_shr = acc_q >> 1;
  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    md_d      = md_q;
    mr_d      = mr_q;
    sgn_d     = sgn_q;
    neg_d     = neg_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          md_d    = multiplicand;
          mr_d    = multiplier;
          sgn_d   = signed_mode & SIGNED_EN;
          state_d = StLoad;
        end
      end
      StLoad: begin
        md_d    = md_mag;
        mr_d    = mr_mag;
        neg_d   = sgn_q & (md_q[WIDTH-1] ^ mr_q[WIDTH-1]);
        acc_d   = '0;
        cnt_d   = '0;
        state_d = mr_mag[0] ? StAdd : StShift;
      end
      StAdd: begin
        acc_d[2*WIDTH:WIDTH] = acc_q[2*WIDTH:WIDTH] + {1'b0, md_q};
        state_d              = StShift;
      end
      StShift: begin
        acc_d = acc_shr;
        if (cnt_q == CntLast) begin
          // Product is registered on entry to DONE so it is valid alongside done.
          product_d = neg_q ? -acc_shr[2*WIDTH-1:0] : acc_shr[2*WIDTH-1:0];
          state_d   = StDone;
        end else begin
          cnt_d   = cnt_inc;
          state_d = mr_q[cnt_inc] ? StAdd : StShift;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      md_q      <= '0;
      mr_q      <= '0;
      sgn_q     <= 1'b0;
      neg_q     <= 1'b0;
      acc_q     <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      md_q      <= md_d;
      mr_q      <= mr_d;
      sgn_q     <= sgn_d;
      neg_q     <= neg_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  assign busy    = (state_q != StIdle);
  assign done    = (state_q == StDone);
  assign product = product_q;

endmodule

// File: tb/tb_seq_mult_param.sv
// Randomised and directed bench for seq_mult_param (WIDTH=8), with a signed-enabled
// instance and a SIGNED_EN=0 instance sharing the same stimulus.
module tb_seq_mult_param;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         signed_mode;
  logic [W-1:0] multiplicand;
  logic [W-1:0] multiplier;
  logic         busy, done;
  logic [2*W-1:0] product;
  logic         busy_u, done_u;
  logic [2*W-1:0] product_u;

  int cyc = 0;
  int total = 0;
  int bad = 0;
  int done_cnt = 0;

  seq_mult_param #(.WIDTH(W), .SIGNED_EN(1'b1)) u_dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .signed_mode  (signed_mode),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  seq_mult_param #(.WIDTH(W), .SIGNED_EN(1'b0)) u_dut_u (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .signed_mode  (signed_mode),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy_u),
    .done         (done_u),
    .product      (product_u)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (done) done_cnt = done_cnt + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: plain arithmetic on the operands.
  function automatic logic [2*W-1:0] ref_prod(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic sm);
    logic signed [2*W-1:0] sp;
    if (sm) begin
      sp = $signed(a) * $signed(b);
      return sp;
    end
    return (2*W)'(a) * (2*W)'(b);
  endfunction

  function automatic int ref_lat(input logic [W-1:0] b, input logic sm);
    int mag;
    mag = int'(b);
    if (sm && b[W-1]) mag = 256 - int'(b);
    return 2 + W + $countones(mag);
  endfunction

  task automatic wait_idle();
    int n = 0;
    while ((busy || busy_u) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", {30'd0, busy, busy_u}, 32'd0);
  endtask

  // Drives start for cycle 0; returns at the negedge of cycle 1 with t0 set.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm,
                          output int t0);
    @(negedge clk);
    start        = 1'b1;
    multiplicand = a;
    multiplier   = b;
    signed_mode  = sm;
    t0           = cyc;
    @(negedge clk);
    start = 1'b0;
    check("busy_cycle1", {31'd0, busy}, 32'd1);
  endtask

  task automatic wait_done(input string tag, input int t0, input int exp_cyc,
                           input logic [2*W-1:0] exp_p, input logic [2*W-1:0] exp_pu);
    int n = 0;
    while (!done && n < 80) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done_seen"}, {31'd0, done}, 32'd1);
    if (done) begin
      check({tag, "_done_cycle"}, cyc - t0, exp_cyc);
      check({tag, "_product"}, {16'd0, product}, {16'd0, exp_p});
      @(negedge clk);
      check({tag, "_done_pulse"}, {30'd0, done, busy}, 32'd0);
    end
    wait_idle();
    check({tag, "_product_nosign"}, {16'd0, product_u}, {16'd0, exp_pu});
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sm);
    int t0;
    start_op(a, b, sm, t0);
    wait_done(tag, t0, ref_lat(b, sm), ref_prod(a, b, sm), ref_prod(a, b, 1'b0));
  endtask

  initial begin
    int t0;
    int hits[$];
    int dc;
    logic [W-1:0] ra, rb;
    logic rs;

    rst = 1'b1; start = 1'b0; signed_mode = 1'b0; multiplicand = '0; multiplier = '0;
    repeat (3) @(negedge clk);
    check("reset_state", {14'd0, busy, done, product}, 32'd0);
    check("reset_state_u", {14'd0, busy_u, done_u, product_u}, 32'd0);
    rst = 1'b0;

    // Directed cases
    run_op("u13x11", 8'd13, 8'd11, 1'b0);
    run_op("uffx00", 8'hFF, 8'h00, 1'b0);
    run_op("uffxff", 8'hFF, 8'hFF, 1'b0);
    run_op("sm3x5", 8'hFD, 8'h05, 1'b1);
    run_op("s80x80", 8'h80, 8'h80, 1'b1);
    run_op("s5xm3", 8'h05, 8'hFD, 1'b1);

    // Start pulsed while busy must be ignored
    start_op(8'd13, 8'd11, 1'b0, t0);
    repeat (4) @(negedge clk);
    start = 1'b1; multiplicand = 8'd2; multiplier = 8'd2;
    @(negedge clk);
    start = 1'b0;
    wait_done("ignore", t0, 13, 16'h008F, 16'h008F);

    // Reset in cycle 4 aborts with no done
    start_op(8'd100, 8'd200, 1'b0, t0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    dc  = done_cnt;
    @(negedge clk);
    rst = 1'b0;
    check("abort_state", {14'd0, busy, busy_u, product}, 32'd0);
    repeat (25) @(negedge clk);
    check("abort_no_done", done_cnt - dc, 32'd0);
    run_op("after_abort", 8'd2, 8'd3, 1'b0);

    // Start held high: back-to-back operations
    @(negedge clk);
    start = 1'b1; multiplicand = 8'd13; multiplier = 8'd11; signed_mode = 1'b0;
    t0 = cyc;
    for (int i = 0; i < 40 && hits.size() < 2; i++) begin
      @(negedge clk);
      if (done) begin
        hits.push_back(cyc - t0);
        check("held_product", {16'd0, product}, 32'h008F);
        if (hits.size() == 2) start = 1'b0;
      end
    end
    start = 1'b0;
    check("held_count", hits.size(), 32'd2);
    if (hits.size() == 2) begin
      check("held_first", hits[0], 32'd13);
      check("held_second", hits[1], 32'd27);
    end
    wait_idle();

    // Randomised operations
    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rs = 1'($urandom);
      run_op("rand", ra, rb, rs);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/seq_mult_param.md
Name: seq_mult_param

Overview:
- Parametrised sequential shift-add multiplier with controller and datapath in one block: WIDTH-bit operands, 2*WIDTH-bit product.
- Next-generation multiplier for the arithmetic section, replacing the fixed 4-bit control-only unit.
- Adds a start/busy/done handshake, operand capture, optional two's-complement mode, and skipping of add cycles for zero multiplier bits.

Parameters:
- WIDTH, 8, operand width in bits; legal range is WIDTH >= 2.
- SIGNED_EN, 1, when 1, signed_mode is honoured; when 0, signed_mode is ignored and all operations are unsigned.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a multiply; sampled only in IDLE.
- signed_mode  input  1  operands are two's complement; captured with start.
- multiplicand  input  WIDTH  operand A; captured with start.
- multiplier  input  WIDTH  operand B; captured with start.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse; product is valid from this cycle.
- product  output  2*WIDTH  result register; holds its value until the next done.

Behaviour:
- Reset: synchronous, active-high, on clk. State goes to IDLE. busy=0, done=0, product=0, all internal registers cleared. Reset mid-operation aborts the operation, and no done pulse is produced.
- States: IDLE, LOAD, ADD, SHIFT, DONE.
- IDLE:
  - If start=1 at an edge, capture multiplicand, multiplier and signed_mode into registers, then go to LOAD.
  - Otherwise stay in IDLE.
  - Later operand changes have no effect on the operation in progress.
- LOAD:
  - sgn = signed_mode & SIGNED_EN.
  - md_r = |A| and mr_r = |B| when sgn=1, else the raw values. Magnitudes are unsigned WIDTH bits, so the most negative value maps to 2^(WIDTH-1).
  - neg = sgn & (A[msb] ^ B[msb]).
  - acc (2*WIDTH+1 bits) = 0, cnt = 0.
  - Next state is ADD if mr_r[0]=1, else SHIFT.
- ADD: acc[2W:W] <= acc[2W:W] + {1'b0, md_r}, with the carry kept in acc[2W]. Next state is always SHIFT.
- SHIFT: acc <= acc >> 1 (logical).
  - If cnt == WIDTH-1, go to DONE.
  - Otherwise cnt <= cnt+1 and go to ADD if mr_r[cnt+1]=1, else SHIFT.
- DONE:
  - product <= neg ? -acc[2W-1:0] : acc[2W-1:0] (two's complement negate).
  - done=1 for this cycle only; next state is IDLE.
- Output timing: product updates at the end of the DONE cycle, so it is valid in the cycle after done, and also combinationally in the done cycle if produced as a next-value. Implementations register product at the entry edge into DONE so that it is valid in the same cycle as done.
- Latency: start is sampled at the edge ending cycle 0. done is high in cycle 2 + WIDTH + P, where P = popcount(mr_r) (the magnitude in signed mode).
- start while busy=1 is ignored; no queuing.
- start held high continuously: DONE returns to IDLE, and the next op starts from that IDLE cycle. There is one IDLE cycle between operations.
- rst and start both high in the same cycle: rst wins.
- cnt width is $clog2(WIDTH). No overflow is possible: 2*WIDTH bits hold every unsigned product and every signed product, including (-2^(W-1))^2.

Test Plan:
- WIDTH=8, unsigned, A=13, B=11 -> product=0x008F, done pulse in cycle 13 (P=3), busy high in cycles 1-13.
- A=0xFF, B=0x00 -> product=0x0000, done in cycle 10. A=0xFF, B=0xFF -> product=0xFE01, done in cycle 18.
- signed_mode=1, A=0xFD (-3), B=0x05 -> product=0xFFF1, done in cycle 12. A=0x80, B=0x80 -> product=0x4000, done in cycle 11.
- SIGNED_EN=0 build, signed_mode=1, A=0xFD, B=0x05 -> product=0x04F1 (253*5).
- Start 13*11, pulse start again with A=2, B=2 in cycle 5 -> ignored, product=0x008F. Then assert rst in cycle 4 of a second op -> busy=0, product=0 next cycle, no done. A following start of 2*3 -> product=0x0006.
- start held high with operands 13*11 -> done pulses in cycles 13 and 27, with product 0x008F both times.
